// File: rtl/cacheline_burst_adaptor.sv
// Line-to-burst adaptor: turns one 256-bit line read/write into a 4-beat memory burst,
// reassembling read beats into a line and pulsing line_resp on completion.
module cacheline_burst_adaptor #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        line_read,
  input  logic                        line_write,
  input  logic [31:0]                 line_address,
  input  logic [BEAT_WIDTH*BEATS-1:0] line_wdata,
  output logic [BEAT_WIDTH*BEATS-1:0] line_rdata,
  output logic                        line_resp,
  output logic                        burst_read,
  output logic                        burst_write,
  output logic [31:0]                 burst_address,
  output logic [BEAT_WIDTH-1:0]       burst_wdata,
  input  logic [BEAT_WIDTH-1:0]       burst_rdata,
  input  logic                        burst_resp
);

  localparam int LINE_WIDTH  = BEAT_WIDTH * BEATS;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      beat_reg;
  logic [31:0]           addr_reg;
  logic [LINE_WIDTH-1:0] wdata_reg;
  logic [LINE_WIDTH-1:0] rdata_reg;
  logic [BEAT_WIDTH-1:0] wbeat [BEATS];
  logic                  last_beat;
  logic                  unused_offset;

  // Offset bits of the requester's address are deliberately dropped.
  assign unused_offset = ^line_address[OFFSET_BITS-1:0];
  assign last_beat     = (beat_reg == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Write wins over a simultaneous read so dirty data is flushed before the fetch.
          if (line_write || line_read) begin
            addr_reg  <= {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            beat_reg  <= '0;
            state_reg <= line_write ? WR_BURST : RD_BURST;
            if (line_write) wdata_reg <= line_wdata;
          end
        end
        RD_BURST, WR_BURST: begin
          if (burst_resp) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= DONE;
            end else begin
              beat_reg <= beat_reg + CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-beat slices of the line: read capture and write-beat selection.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wbeat[gi] = wdata_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_reg[gi*BEAT_WIDTH +: BEAT_WIDTH] <= '0;
        end else if (state_reg == RD_BURST && burst_resp && beat_reg == CNT_W'(gi)) begin
          rdata_reg[gi*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
        end
      end
    end
  endgenerate

  assign line_rdata    = rdata_reg;
  assign line_resp     = (state_reg == DONE);
  assign burst_read    = (state_reg == RD_BURST);
  assign burst_write   = (state_reg == WR_BURST);
  assign burst_address = addr_reg;
  assign burst_wdata   = (state_reg == WR_BURST) ? wbeat[beat_reg] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed + randomized bench for cacheline_burst_adaptor; a bench-side memory
// model supplies read beats and predicts line_rdata, burst_address and latency.
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  int tests = 0;
  int fails = 0;
  logic [255:0] exp_rdata;

  always #5 clk = ~clk;

  cacheline_burst_adaptor dut (
    .clk(clk), .rst_n(rst_n),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One line transaction; rline is what memory returns, gap is idle cycles before each beat.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [255:0] rline, input int gap);
    logic [31:0] aligned;
    int cyc;
    aligned = addr & 32'hFFFF_FFE0;
    line_read = rd; line_write = wr; line_address = addr; line_wdata = wdata;
    step();
    cyc = 1;
    // Post-accept changes must not leak into the running burst.
    line_address = $urandom;
    line_wdata   = rand256();
    check("burst_read_start", burst_read, !wr);
    check("burst_write_start", burst_write, wr);
    check("burst_address", burst_address, aligned);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap + (k == 0 ? 1 : 0); g++) begin
        if (k > 0) begin
          check("req_held", {burst_read, burst_write}, {!wr, wr});
          if (wr) check("wdata_held", burst_wdata, wdata[64*k +: 64]);
        end
        step();
        cyc++;
      end
      burst_resp  = 1'b1;
      burst_rdata = rline[64*k +: 64];
      if (wr) check("burst_wdata", burst_wdata, wdata[64*k +: 64]);
      check("burst_address_hold", burst_address, aligned);
      check("line_resp_early", line_resp, 1'b0);
      step();
      cyc++;
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
    end
    if (!wr) exp_rdata = rline;
    check("line_resp", line_resp, 1'b1);
    check("line_rdata", line_rdata, exp_rdata);
    check("req_drop", {burst_read, burst_write}, 2'b00);
    if (gap == 0) check("latency", cyc, 6);
    line_read = 1'b0; line_write = 1'b0;
    step();
    check("line_resp_width", line_resp, 1'b0);
    check("line_rdata_hold", line_rdata, exp_rdata);
    $display("[TB] txn rd=%0d wr=%0d addr=%08h gap=%0d", rd, wr, addr, gap);
  endtask

  task automatic stray_resp();
    burst_resp  = 1'b1;
    burst_rdata = {$urandom, $urandom};
    step();
    burst_resp = 1'b0;
    check("stray_req", {burst_read, burst_write, line_resp}, 3'b000);
    check("stray_rdata", line_rdata, exp_rdata);
    $display("[TB] stray burst_resp in IDLE");
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] rl;
    int op;
    rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    exp_rdata = '0;
    step(); step();
    check("rst_ctrl", {line_resp, burst_read, burst_write}, 3'b000);
    check("rst_addr", burst_address, 32'h0);
    check("rst_wdata", burst_wdata, 64'h0);
    check("rst_rdata", line_rdata, 256'h0);
    $display("[TB] reset state checked");
    rst_n = 1'b1;
    step();

    // Read with back-to-back beats at minimum latency.
    pat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h0000_1040, 256'h0, pat, 0);

    // Unaligned write with 2-cycle gaps between beats.
    pat = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
           64'hFFFF_EEEE_0000_1111, 64'h0123_4567_DDCC_BBAA};
    run_txn(1'b0, 1'b1, 32'h0000_2068, pat, rand256(), 2);

    // Both requests high: write serviced, read line unchanged.
    run_txn(1'b1, 1'b1, 32'h0000_0300, rand256(), rand256(), 0);

    // Reset after the second read beat aborts the burst.
    rl = rand256();
    line_read = 1'b1; line_address = 32'h0000_4000;
    step(); step();
    burst_resp = 1'b1; burst_rdata = rl[63:0];
    step();
    burst_rdata = rl[127:64];
    step();
    burst_resp = 1'b0; rst_n = 1'b0;
    step();
    exp_rdata = '0;
    check("abort_read", burst_read, 1'b0);
    check("abort_rdata", line_rdata, 256'h0);
    check("abort_resp", line_resp, 1'b0);
    rst_n = 1'b1; line_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_resp", line_resp, 1'b0);
    end
    $display("[TB] reset mid-burst checked");
    run_txn(1'b1, 1'b0, 32'h0000_4000, 256'h0, rand256(), 1);

    // Back-to-back write then read of the same line, plus a stray beat in IDLE.
    pat = rand256();
    run_txn(1'b0, 1'b1, 32'h0000_0100, pat, rand256(), 0);
    run_txn(1'b1, 1'b0, 32'h0000_0100, 256'h0, pat, 0);
    stray_resp();

    for (int n = 0; n < 20; n++) begin
      op = $urandom_range(0, 2);
      run_txn(op != 1, op != 0, $urandom, rand256(), rand256(), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) stray_resp();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
